// File: rtl/ofdm_subcarrier_mapper.sv
// ofdm_subcarrier_mapper
// Collects one symbol of modulated I/Q samples, then emits a full FFT_SIZE-bin
// frame in natural bin order. Data goes on SUBCARRIER_MASK bins and zeros go
// everywhere else. Downstream back-pressure comes in on i_wayt_recive_data.
// Optional feature macro: OFDM_PILOT_EN adds BPSK pilots on PILOT_MASK bins.
// The pilot sign comes from a per-frame 7-bit LFSR (x^7+x^4+1).
module ofdm_subcarrier_mapper #(
  parameter int                  DATA_SIZE       = 16,
  parameter int                  FFT_SIZE        = 256,
  parameter int                  LOG2_FFT        = 8,
  parameter logic [FFT_SIZE-1:0] SUBCARRIER_MASK =
    {{100{1'b1}}, {55{1'b0}}, {100{1'b1}}, 1'b0},
  parameter logic [FFT_SIZE-1:0] PILOT_MASK      = '0,
  parameter int                  PILOT_AMP       = 16'h2000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 in_data_en,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  output logic                 o_flag_ready_recive,
  input  logic                 i_wayt_recive_data,
  output logic                 o_valid_data,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 out_done,
  output logic [15:0]          o_counter_data,
  output logic [15:0]          o_symbol_cnt
);

  localparam int NUM_DATA = $countones(SUBCARRIER_MASK);
  // A zero-data mask still needs a legal one-entry array.
  localparam int DEPTH    = (NUM_DATA > 0) ? NUM_DATA : 1;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LOG2_FFT-1:0] LAST_BIN  = LOG2_FFT'(FFT_SIZE - 1);
  localparam logic [AW-1:0]       LAST_FILL = AW'(NUM_DATA - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          fill_cnt;
  logic [AW-1:0]          rd_ptr;
  logic [LOG2_FFT-1:0]    bin;
  logic [2*DATA_SIZE-1:0] mem [DEPTH];

  logic                   wr_en;
  logic                   fill_last;
  logic                   bin_adv;
  logic                   bin_last;
  logic                   bin_data;
  logic [DATA_SIZE-1:0]   pilot_i;
  logic                   bin_pilot;

  assign o_flag_ready_recive = (state == FILL) && (NUM_DATA != 0);
  assign wr_en     = o_flag_ready_recive && in_data_en;
  assign fill_last = (fill_cnt == LAST_FILL);
  assign bin_adv   = (state == EMIT) && i_wayt_recive_data;
  assign bin_last  = (bin == LAST_BIN);
  assign bin_data  = SUBCARRIER_MASK[bin];

`ifdef OFDM_PILOT_EN
  localparam logic [DATA_SIZE-1:0] PAMP = DATA_SIZE'(PILOT_AMP);
  logic [6:0] lfsr;

  // Pilot sign LFSR, advanced once per frame alongside the last-bin beat.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      lfsr <= 7'h7F;
    else if (bin_adv && bin_last)
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
  end

  assign pilot_i   = lfsr[6] ? (DATA_SIZE'(0) - PAMP) : PAMP;
  assign bin_pilot = PILOT_MASK[bin];
`else
  assign pilot_i   = '0;
  assign bin_pilot = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= FILL;
    else         state <= state_nxt;
  end

  // Next-state: FILL until the buffer is full, then EMIT until the last bin.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (NUM_DATA == 0)
          state_nxt = EMIT;
        else if (wr_en && fill_last)
          state_nxt = EMIT;
      end
      EMIT: begin
        if (bin_adv && bin_last)
          state_nxt = (NUM_DATA == 0) ? EMIT : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Sample buffer, written in arrival order. It has no reset because it is storage only.
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[fill_cnt] <= {in_data_i, in_data_q};
  end

  // Fill counter. It wraps to zero on the write that completes the symbol.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      fill_cnt <= '0;
    else if (wr_en)
      fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
  end

  // Emit datapath. The buffer read is registered straight into the output.
  // A stall clears only the valid flag and holds all other outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bin            <= '0;
      rd_ptr         <= '0;
      o_valid_data   <= 1'b0;
      out_done       <= 1'b0;
      out_data_i     <= '0;
      out_data_q     <= '0;
      o_counter_data <= '0;
      o_symbol_cnt   <= '0;
    end else if (state == FILL) begin
      o_valid_data <= 1'b0;
      out_done     <= 1'b0;
    end else if (bin_adv) begin
      o_valid_data   <= 1'b1;
      o_counter_data <= 16'(bin);
      out_done       <= bin_last;
      if (bin_data) begin
        out_data_i <= mem[rd_ptr][2*DATA_SIZE-1:DATA_SIZE];
        out_data_q <= mem[rd_ptr][DATA_SIZE-1:0];
      end else if (bin_pilot) begin
        out_data_i <= pilot_i;
        out_data_q <= '0;
      end else begin
        out_data_i <= '0;
        out_data_q <= '0;
      end
      if (bin_last) begin
        bin          <= '0;
        rd_ptr       <= '0;
        o_symbol_cnt <= o_symbol_cnt + 16'd1;
      end else begin
        bin <= bin + 1'b1;
        if (bin_data)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end else begin
      o_valid_data <= 1'b0;
    end
  end

endmodule
